fetchbuffer: RTL and testbench

- Responder end of the fetch-stage instruction port.
- Accepts per-cycle halfword-aligned PC requests and returns one complete RV32IC instruction (16- or 32-bit) combinationally from internal storage.
- Independently prefetches sequential 32-bit words from instruction memory over the standard mem_in/mem_out handshake.
- Sits between the fetch stage and the imem/cache port and hides misaligned 32-bit instructions that straddle a word boundary.

---
 rtl/fetchbuffer.sv | 160 ++++++++++++++++
 tb/tb_fetchbuffer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetchbuffer.sv
// Fetch-stage responder: a halfword ring buffer fed by sequential word prefetch from imem,
// returning whole RV32IC instructions (including ones that straddle a word boundary) with zero latency.
module fetchbuffer #(
  parameter int unsigned DEPTH      = 4,
  parameter logic [31:0] RESET_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetchbuffer_in_mem_valid_i,
  input  logic        fetchbuffer_in_mem_fence_i,
  input  logic        fetchbuffer_in_mem_instr_i,
  input  logic [31:0] fetchbuffer_in_mem_addr_i,
  input  logic [31:0] fetchbuffer_in_mem_wdata_i,
  input  logic [3:0]  fetchbuffer_in_mem_wstrb_i,
  output logic        fetchbuffer_out_mem_ready_o,
  output logic [31:0] fetchbuffer_out_mem_rdata_o,
  output logic        imem_in_mem_valid_o,
  output logic        imem_in_mem_fence_o,
  output logic        imem_in_mem_instr_o,
  output logic [31:0] imem_in_mem_addr_o,
  output logic [31:0] imem_in_mem_wdata_o,
  output logic [3:0]  imem_in_mem_wstrb_o,
  input  logic        imem_out_mem_ready_i,
  input  logic [31:0] imem_out_mem_rdata_i
);
  localparam int unsigned HW = 2 * DEPTH;
  localparam int unsigned HB = $clog2(HW);
  localparam int unsigned WB = $clog2(DEPTH);
  localparam logic [HB:0] ONE       = (HB+1)'(1);
  localparam logic [HB:0] TWO       = (HB+1)'(2);
  localparam logic [HB:0] ISSUE_MAX = (HB+1)'(HW - 2);

  logic [15:0]   buf_q [HW];
  logic [WB-1:0] wptr_q, wptr_d;
  logic [HB-1:0] rptr_q, rptr_d;
  logic [HB:0]   count_q, count_d;
  logic [31:0]   rd_pc_q, rd_pc_d;
  logic [31:0]   fetch_addr_q, fetch_addr_d;
  logic [31:0]   imem_addr_q, imem_addr_d;
  logic          pending_q, pending_d;
  logic          discard_q, discard_d;
  logic          fence_req_q, fence_req_d;
  logic          imem_fence_q, imem_fence_d;
  logic          skip_q, skip_d;

  logic [15:0] h0, h1;
  logic        is32, hit, ready, flush, ret, ret_write, issue;
  logic [HB:0] n_cons, n_add;
  logic        unused_in;

  assign unused_in = ^{fetchbuffer_in_mem_instr_i, fetchbuffer_in_mem_wdata_i, fetchbuffer_in_mem_wstrb_i};

  assign h0 = buf_q[rptr_q];
  assign h1 = buf_q[rptr_q + HB'(1)];

  always_comb begin
    is32  = (h0[1:0] == 2'b11);
    hit   = fetchbuffer_in_mem_valid_i & ~fetchbuffer_in_mem_fence_i &
            (fetchbuffer_in_mem_addr_i == rd_pc_q);
    flush = fetchbuffer_in_mem_valid_i &
            (fetchbuffer_in_mem_fence_i | (fetchbuffer_in_mem_addr_i != rd_pc_q));
    ready = hit & (is32 ? (count_q >= TWO) : (count_q >= ONE));
    fetchbuffer_out_mem_ready_o = ready;
    fetchbuffer_out_mem_rdata_o = ready ? (is32 ? {h1, h0} : {16'h0, h0}) : 32'h0;

    ret       = imem_out_mem_ready_i & pending_q;
    ret_write = ret & ~discard_q & ~flush;
    n_cons    = ready ? (is32 ? TWO : ONE) : '0;
    // the first word of a misaligned stream only contributes its upper half
    n_add     = ret_write ? (skip_q ? ONE : TWO) : '0;

    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    count_d      = count_q;
    rd_pc_d      = rd_pc_q;
    fetch_addr_d = fetch_addr_q;
    imem_addr_d  = imem_addr_q;
    discard_d    = discard_q;
    fence_req_d  = fence_req_q;
    imem_fence_d = imem_fence_q;
    skip_d       = skip_q;
    pending_d    = pending_q & ~ret;

    if (flush) begin
      count_d      = '0;
      wptr_d       = '0;
      rd_pc_d      = fetchbuffer_in_mem_addr_i;
      rptr_d       = {{(HB-1){1'b0}}, fetchbuffer_in_mem_addr_i[1]};
      fetch_addr_d = {fetchbuffer_in_mem_addr_i[31:2], 2'b00};
      skip_d       = fetchbuffer_in_mem_addr_i[1];
      discard_d    = pending_q & ~ret;
      fence_req_d  = fence_req_q | fetchbuffer_in_mem_fence_i;
    end else begin
      count_d = count_q + n_add - n_cons;
      if (ready) begin
        rptr_d  = rptr_q + (is32 ? HB'(2) : HB'(1));
        rd_pc_d = rd_pc_q + (is32 ? 32'd4 : 32'd2);
      end
      if (ret_write) begin
        wptr_d = wptr_q + WB'(1);
        skip_d = 1'b0;
      end
      if (ret) discard_d = 1'b0;
    end

    if (ret) imem_fence_d = 1'b0;

    // the in-flight word is reserved as a full word even when half of it will be skipped
    issue = ~pending_d & ~flush & (count_d <= ISSUE_MAX);
    if (issue) begin
      pending_d    = 1'b1;
      imem_addr_d  = fetch_addr_d;
      fetch_addr_d = fetch_addr_d + 32'd4;
      imem_fence_d = fence_req_d;
      fence_req_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      rd_pc_q      <= RESET_ADDR;
      fetch_addr_q <= {RESET_ADDR[31:2], 2'b00};
      imem_addr_q  <= '0;
      pending_q    <= 1'b0;
      discard_q    <= 1'b0;
      fence_req_q  <= 1'b0;
      imem_fence_q <= 1'b0;
      skip_q       <= 1'b0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      rd_pc_q      <= rd_pc_d;
      fetch_addr_q <= fetch_addr_d;
      imem_addr_q  <= imem_addr_d;
      pending_q    <= pending_d;
      discard_q    <= discard_d;
      fence_req_q  <= fence_req_d;
      imem_fence_q <= imem_fence_d;
      skip_q       <= skip_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ret_write) begin
      buf_q[{wptr_q, 1'b0}] <= imem_out_mem_rdata_i[15:0];
      buf_q[{wptr_q, 1'b1}] <= imem_out_mem_rdata_i[31:16];
    end
  end

  assign imem_in_mem_valid_o = pending_q;
  assign imem_in_mem_instr_o = pending_q;
  assign imem_in_mem_fence_o = imem_fence_q;
  assign imem_in_mem_addr_o  = imem_addr_q;
  assign imem_in_mem_wdata_o = 32'h0;
  assign imem_in_mem_wstrb_o = 4'h0;
endmodule

// File: tb/tb_fetchbuffer.sv
// Bench for fetchbuffer: behavioural imem with adjustable latency, table-driven fetch vectors
// checked through an expected-result queue, plus hand-written redirect/fence/full/reset sequences.
module tb_fetchbuffer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        f_valid, f_fence;
  logic [31:0] f_addr;
  logic        f_ready;
  logic [31:0] f_rdata;
  logic        i_valid, i_fence, i_instr;
  logic [31:0] i_addr, i_wdata;
  logic [3:0]  i_wstrb;
  logic        m_ready;
  logic [31:0] m_rdata;

  fetchbuffer #(.DEPTH(4), .RESET_ADDR(32'h0)) dut (
    .clk                         (clk),
    .rst                         (rst),
    .fetchbuffer_in_mem_valid_i  (f_valid),
    .fetchbuffer_in_mem_fence_i  (f_fence),
    .fetchbuffer_in_mem_instr_i  (1'b1),
    .fetchbuffer_in_mem_addr_i   (f_addr),
    .fetchbuffer_in_mem_wdata_i  (32'h0),
    .fetchbuffer_in_mem_wstrb_i  (4'h0),
    .fetchbuffer_out_mem_ready_o (f_ready),
    .fetchbuffer_out_mem_rdata_o (f_rdata),
    .imem_in_mem_valid_o         (i_valid),
    .imem_in_mem_fence_o         (i_fence),
    .imem_in_mem_instr_o         (i_instr),
    .imem_in_mem_addr_o          (i_addr),
    .imem_in_mem_wdata_o         (i_wdata),
    .imem_in_mem_wstrb_o         (i_wstrb),
    .imem_out_mem_ready_i        (m_ready),
    .imem_out_mem_rdata_i        (m_rdata)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [256];
  int          mem_lat = 0;
  bit          busy = 0;
  int          lat_cnt = 0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] last_resp_addr = 32'h0;
  logic [32:0] req_log [$];
  logic [31:0] exp_q [$];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [32:0] log_at(input int idx);
    if (idx < req_log.size()) return req_log[idx];
    return '1;
  endfunction

  // imem model: captures a request at the falling edge, answers mem_lat falling edges later
  initial begin
    m_ready = 1'b0;
    m_rdata = 32'h0;
    forever begin
      @(negedge clk);
      m_ready = 1'b0;
      m_rdata = 32'h0;
      if (rst !== 1'b1 || i_valid !== 1'b1) begin
        busy = 0;
      end else begin
        if (!busy) begin
          busy     = 1;
          lat_cnt  = mem_lat;
          req_addr = i_addr;
          req_log.push_back({i_fence, i_addr});
        end
        if (lat_cnt == 0) begin
          m_ready        = 1'b1;
          m_rdata        = mem[req_addr[9:2]];
          last_resp_addr = req_addr;
          busy           = 0;
        end else begin
          lat_cnt--;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  // Present pc until it is accepted; expected word goes through the scoreboard queue.
  task automatic fetch(input logic [31:0] pc, input logic [31:0] exp, input int budget);
    bit got;
    got = 0;
    exp_q.push_back(exp);
    f_valid = 1'b1;
    f_fence = 1'b0;
    f_addr  = pc;
    for (int i = 0; i < budget && !got; i++) begin
      #1;
      if (f_ready === 1'b1) begin
        got = 1;
        check($sformatf("fetch_rdata_pc_%h", pc), f_rdata, exp_q.pop_front());
      end else begin
        check("rdata_zero_when_not_ready", f_rdata, 32'h0);
      end
      step();
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL fetch_timeout pc=%h: no ready within %0d cycles, expected %h", pc, budget, exp);
      void'(exp_q.pop_front());
    end
    f_valid = 1'b0;
  endtask

  task automatic quiesce();
    int idle;
    idle = 0;
    f_valid = 1'b0;
    f_fence = 1'b0;
    for (int i = 0; i < 80 && idle < 2; i++) begin
      step();
      if (i_valid === 1'b0) idle++;
      else idle = 0;
    end
    check("quiesce_imem_idle", {31'b0, i_valid}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0001_0001;
    mem[0]   = 32'h00A0_0093;
    mem[1]   = 32'h4505_0505;
    mem[2]   = 32'h0093_0001;
    mem[3]   = 32'h1234_00A0;
    mem[4]   = 32'h0041_0113;
    mem[16]  = 32'h0093_5555;
    mem[17]  = 32'h0001_00A0;
    mem[32]  = 32'h0010_0013;
    mem[33]  = 32'h0020_0013;
    mem[34]  = 32'h0030_0013;
    mem[35]  = 32'h0040_0013;
    mem[64]  = 32'h8082_FFFF;
    mem[128] = 32'h0050_0093;

    tbl[0] = '{32'h4,  32'h0000_0505};
    tbl[1] = '{32'h6,  32'h0000_4505};
    tbl[2] = '{32'h8,  32'h0000_0001};
    tbl[3] = '{32'hA,  32'h00A0_0093};
    tbl[4] = '{32'hE,  32'h0000_1234};
    tbl[5] = '{32'h10, 32'h0041_0113};

    rst = 1'b0;
    f_valid = 1'b0;
    f_fence = 1'b0;
    f_addr = 32'h0;
    repeat (3) step();
    check("reset_ready", {31'b0, f_ready}, 32'h0);
    check("reset_rdata", f_rdata, 32'h0);
    check("reset_imem_valid", {31'b0, i_valid}, 32'h0);
    check("reset_imem_addr", i_addr, 32'h0);
    check("reset_imem_fence", {31'b0, i_fence}, 32'h0);
    check("reset_imem_wdata", i_wdata, 32'h0);
    check("reset_imem_wstrb", {28'b0, i_wstrb}, 32'h0);

    // first instruction: ready exactly one cycle after the word returns
    f_valid = 1'b1;
    f_addr  = 32'h0;
    #1;
    check("empty_not_ready", {31'b0, f_ready}, 32'h0);
    req_log.delete();
    rst = 1'b1;
    step();
    check("first_req_valid", {31'b0, i_valid}, 32'h1);
    check("first_req_instr", {31'b0, i_instr}, 32'h1);
    check("first_cycle_not_ready", {31'b0, f_ready}, 32'h0);
    step();
    exp_q.push_back(32'h00A0_0093);
    check("first_ready", {31'b0, f_ready}, 32'h1);
    check("first_rdata", f_rdata, exp_q.pop_front());
    step();
    f_valid = 1'b0;

    foreach (tbl[i]) fetch(tbl[i].pc, tbl[i].exp, 20);
    check("seq_req0", log_at(0)[31:0], 32'h0);
    check("seq_req1", log_at(1)[31:0], 32'h4);
    check("seq_req2", log_at(2)[31:0], 32'h8);

    // straddling 32-bit instruction at 0x42 with slow memory
    mem_lat = 3;
    fetch(32'h42, 32'h00A0_0093, 40);
    check("straddle_waited_for_second_word", last_resp_addr, 32'h44);
    fetch(32'h46, 32'h0000_0001, 40);

    // full buffer: exactly four words prefetched, then issue stops until a consume
    mem_lat = 0;
    quiesce();
    f_valid = 1'b1;
    f_addr  = 32'h80;
    step();
    f_valid = 1'b0;
    req_log.delete();
    repeat (15) step();
    check("full_req_count", req_log.size(), 32'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("full_req_addr%0d", i), log_at(i)[31:0], 32'h80 + 32'(4 * i));
    check("full_imem_idle", {31'b0, i_valid}, 32'h0);
    fetch(32'h80, 32'h0010_0013, 10);
    step();
    check("full_reissue_addr", log_at(4)[31:0], 32'h90);
    fetch(32'h84, 32'h0020_0013, 10);
    fetch(32'h88, 32'h0030_0013, 10);
    fetch(32'h8C, 32'h0040_0013, 10);

    // redirect to a misaligned target while the request to 0x10 is outstanding
    quiesce();
    mem_lat = 6;
    f_valid = 1'b1;
    f_addr  = 32'h10;
    step();
    f_valid = 1'b0;
    step();
    step();
    check("outstanding_valid", {31'b0, i_valid}, 32'h1);
    check("outstanding_addr", i_addr, 32'h10);
    req_log.delete();
    fetch(32'h102, 32'h0000_8082, 40);
    check("redirect_first_req", log_at(0)[31:0], 32'h100);
    f_valid = 1'b1;
    f_addr  = 32'h104;
    #1;
    check("skipped_half_not_counted", {31'b0, f_ready}, 32'h0);
    fetch(32'h104, 32'h0000_0001, 20);

    // fence: flush and tag the next imem request
    mem_lat = 0;
    quiesce();
    req_log.delete();
    f_valid = 1'b1;
    f_fence = 1'b1;
    f_addr  = 32'h200;
    #1;
    check("fence_not_ready", {31'b0, f_ready}, 32'h0);
    step();
    f_valid = 1'b0;
    f_fence = 1'b0;
    repeat (4) step();
    check("fence_req_addr", log_at(0)[31:0], 32'h200);
    check("fence_req_flag", {31'b0, log_at(0)[32]}, 32'h1);
    check("fence_next_addr", log_at(1)[31:0], 32'h204);
    check("fence_next_flag", {31'b0, log_at(1)[32]}, 32'h0);
    fetch(32'h200, 32'h0050_0093, 10);

    // reset in the middle of a running stream
    mem_lat = 2;
    fetch(32'h204, 32'h0000_0001, 20);
    rst = 1'b0;
    f_valid = 1'b1;
    f_addr  = 32'h0;
    step();
    check("midreset_ready", {31'b0, f_ready}, 32'h0);
    check("midreset_imem_valid", {31'b0, i_valid}, 32'h0);
    step();
    check("midreset_imem_addr", i_addr, 32'h0);
    rst = 1'b1;
    fetch(32'h0, 32'h00A0_0093, 20);
    fetch(32'h4, 32'h0000_0505, 20);

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
